// File: rtl/clk_div_monitor.sv
// Watches a divided clock sampled as data in the clk domain: measures its period and high time,
// locks after LOCK_COUNT consecutive periods match i_exp_period, and flags mismatches and stalls.
module clk_div_monitor #(
    parameter int WIDTH      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             div_clk,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_exp_period,
    input  logic             i_clr_err,
    output logic             o_rise,
    output logic             o_fall,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high,
    output logic             o_locked,
    output logic             o_err,
    output logic [7:0]       o_err_cnt
);

    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam int               GOOD_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        MEAS,
        LOCKED
    } state_t;

    state_t            state;
    logic              s1, s2, s3;
    logic [WIDTH-1:0]  cnt;
    logic [WIDTH-1:0]  hcnt;
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_inc;

    logic rise, fall;
    logic measuring;
    logic period_match;
    logic timeout;
    logic mismatch_err;
    logic err_event;

    assign rise         = s2 & ~s3;
    assign fall         = ~s2 & s3;
    assign measuring    = (state == MEAS) || (state == LOCKED);
    assign period_match = (cnt == i_exp_period);
    assign timeout      = measuring && !rise && (cnt == CNT_MAX);
    assign mismatch_err = (state == LOCKED) && rise && !period_match;
    // Disable has priority: nothing counted in the cycle the monitor is being shut down.
    assign err_event    = i_enable && (timeout || mismatch_err);
    assign good_inc     = (good_cnt == GOOD_LOCK) ? good_cnt : good_cnt + 1'b1;

    // div_clk is asynchronous to clk, so two flops absorb metastability before edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            s3     <= 1'b0;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, so the
            // chain shifts by exactly one stage per clock regardless of statement order.
            s1     <= div_clk;
            s2     <= s1;
            s3     <= s2;
            o_rise <= rise;
            o_fall <= fall;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            good_cnt  <= '0;
            o_period  <= '0;
            o_high    <= '0;
            o_locked  <= 1'b0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            o_err <= err_event;

            if (i_clr_err) begin
                o_err_cnt <= '0;
            end else if (err_event && (o_err_cnt != 8'hFF)) begin
                o_err_cnt <= o_err_cnt + 8'd1;
            end

            if (!i_enable) begin
                state    <= IDLE;
                cnt      <= '0;
                hcnt     <= '0;
                good_cnt <= '0;
                o_locked <= 1'b0;
            end else begin
                if (state == IDLE) begin
                    hcnt <= '0;
                end else begin
                    if (rise) begin
                        hcnt <= WIDTH'(1);
                    end else if (s2 && (hcnt != CNT_MAX)) begin
                        hcnt <= hcnt + 1'b1;
                    end
                    if (fall) begin
                        o_high <= hcnt;
                    end
                end

                case (state)
                    IDLE: begin
                        state    <= ACQ;
                        cnt      <= '0;
                        good_cnt <= '0;
                    end
                    ACQ: begin
                        // The first edge only opens a measurement window; no period exists yet.
                        if (rise) begin
                            state <= MEAS;
                            cnt   <= WIDTH'(1);
                        end else begin
                            cnt <= '0;
                        end
                    end
                    MEAS, LOCKED: begin
                        if (rise) begin
                            o_period <= cnt;
                            cnt      <= WIDTH'(1);
                            if (period_match) begin
                                good_cnt <= good_inc;
                                if (good_inc == GOOD_LOCK) begin
                                    state    <= LOCKED;
                                    o_locked <= 1'b1;
                                end
                            end else begin
                                good_cnt <= '0;
                                state    <= MEAS;
                                o_locked <= 1'b0;
                            end
                        end else if (cnt == CNT_MAX) begin
                            // Stalled div_clk: report a full-scale period and start over.
                            o_period <= CNT_MAX;
                            cnt      <= '0;
                            good_cnt <= '0;
                            state    <= ACQ;
                            o_locked <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: a table of div_clk waveforms with hand-computed results,
// followed by hand-written sequences for timeout, enable, reset and error-counter corners.
module tb_clk_div_monitor;

    logic       clk;
    logic       resetn;
    logic       div_clk;
    logic       i_enable;
    logic [7:0] i_exp_period;
    logic       i_clr_err;
    logic       o_rise;
    logic       o_fall;
    logic [7:0] o_period;
    logic [7:0] o_high;
    logic       o_locked;
    logic       o_err;
    logic [7:0] o_err_cnt;

    clk_div_monitor #(.WIDTH(8), .LOCK_COUNT(4)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .div_clk     (div_clk),
        .i_enable    (i_enable),
        .i_exp_period(i_exp_period),
        .i_clr_err   (i_clr_err),
        .o_rise      (o_rise),
        .o_fall      (o_fall),
        .o_period    (o_period),
        .o_high      (o_high),
        .o_locked    (o_locked),
        .o_err       (o_err),
        .o_err_cnt   (o_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int err_pulses  = 0;
    int rise_pulses = 0;
    int fall_pulses = 0;

    // Each vector: div_clk low for lo cycles then high for hi cycles, repeated n times.
    typedef struct {
        int lo;
        int hi;
        int n;
        int e_period;
        int e_high;
        int e_locked;
        int e_err_cnt;
        int e_errs;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (o_err)  err_pulses++;
        if (o_rise) rise_pulses++;
        if (o_fall) fall_pulses++;
    endtask

    task automatic run_periods(input int lo, input int hi, input int n);
        for (int p = 0; p < n; p++) begin
            div_clk = 1'b0;
            repeat (lo) tick();
            div_clk = 1'b1;
            repeat (hi) tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish within 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waited;
        bit seen;

        // Expected period at each rise = previous high time + current low time.
        vecs[0] = '{3, 4, 1,   0, 0, 0, 0, 0};  // first rise only acquires
        vecs[1] = '{3, 4, 1,   7, 4, 0, 0, 0};
        vecs[2] = '{3, 4, 2,   7, 4, 0, 0, 0};
        vecs[3] = '{3, 4, 1,   7, 4, 1, 0, 0};  // fourth match locks
        vecs[4] = '{4, 4, 1,   8, 4, 0, 1, 1};  // stretched period while locked
        vecs[5] = '{3, 4, 3,   7, 4, 0, 1, 0};
        vecs[6] = '{3, 4, 1,   7, 4, 1, 1, 0};  // relock after four good periods
        vecs[7] = '{2, 5, 1,   6, 4, 0, 2, 1};  // short period while locked
        vecs[8] = '{3, 4, 1,   8, 5, 0, 2, 0};  // mismatch in MEAS: silent
        vecs[9] = '{3, 4, 4,   7, 4, 1, 2, 0};

        resetn       = 1'b0;
        div_clk      = 1'b0;
        i_enable     = 1'b1;
        i_exp_period = 8'd7;
        i_clr_err    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rise",    o_rise,    0);
        check("rst_fall",    o_fall,    0);
        check("rst_period",  o_period,  0);
        check("rst_high",    o_high,    0);
        check("rst_locked",  o_locked,  0);
        check("rst_err",     o_err,     0);
        check("rst_err_cnt", o_err_cnt, 0);
        resetn = 1'b1;

        for (int i = 0; i < 10; i++) begin
            err_pulses  = 0;
            rise_pulses = 0;
            fall_pulses = 0;
            run_periods(vecs[i].lo, vecs[i].hi, vecs[i].n);
            check($sformatf("v%0d_period", i),  o_period,    vecs[i].e_period);
            check($sformatf("v%0d_high", i),    o_high,      vecs[i].e_high);
            check($sformatf("v%0d_locked", i),  o_locked,    vecs[i].e_locked);
            check($sformatf("v%0d_err_cnt", i), o_err_cnt,   vecs[i].e_err_cnt);
            check($sformatf("v%0d_err_pulses", i), err_pulses, vecs[i].e_errs);
            check($sformatf("v%0d_rises", i),   rise_pulses, vecs[i].n);
            check($sformatf("v%0d_falls", i),   fall_pulses, (i == 0) ? 0 : vecs[i].n);
        end

        // Timeout: locked with cnt = 2 at the end of the last high phase; hold div_clk low.
        err_pulses = 0;
        waited     = 0;
        seen       = 1'b0;
        div_clk    = 1'b0;
        for (int k = 1; k <= 300 && !seen; k++) begin
            tick();
            if (o_err) begin
                seen   = 1'b1;
                waited = k;
            end
        end
        check("timeout_cycles",  waited,    254);
        check("timeout_period",  o_period,  255);
        check("timeout_locked",  o_locked,  0);
        check("timeout_err_cnt", o_err_cnt, 3);
        repeat (5) tick();
        check("timeout_single_err", err_pulses, 1);
        run_periods(3, 4, 1);
        check("timeout_reacq_period",  o_period,  255);
        check("timeout_reacq_err_cnt", o_err_cnt, 3);

        // Enable dropped while locked.
        run_periods(3, 4, 4);
        check("en_locked_before", o_locked, 1);
        i_enable = 1'b0;
        tick();
        check("en_drop_locked", o_locked, 0);
        check("en_drop_period", o_period, 7);
        run_periods(4, 5, 1);
        check("en_off_period_held", o_period,  7);
        check("en_off_err_cnt",     o_err_cnt, 3);
        i_enable = 1'b1;

        // Asynchronous reset in the middle of a period.
        err_pulses = 0;
        div_clk    = 1'b0;
        tick();
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_period",  o_period,  0);
        check("midrst_high",    o_high,    0);
        check("midrst_locked",  o_locked,  0);
        check("midrst_err_cnt", o_err_cnt, 0);
        check("midrst_err",     o_err,     0);
        tick();
        tick();
        resetn = 1'b1;
        repeat (6) tick();
        check("midrst_no_err", err_pulses, 0);
        run_periods(3, 4, 1);
        check("postrst_first_rise_period", o_period, 0);
        run_periods(3, 4, 1);
        check("postrst_second_rise_period", o_period, 7);

        // Error counter saturation: 260 lock/mismatch cycles at an expected period of 5.
        resetn = 1'b0;
        tick();
        resetn       = 1'b1;
        i_exp_period = 8'd5;
        err_pulses   = 0;
        run_periods(2, 3, 1);
        for (int it = 0; it < 260; it++) begin
            run_periods(2, 3, 4);
            run_periods(3, 3, 1);
            if (it == 9) check("sat_err_cnt_10", o_err_cnt, 10);
        end
        check("sat_err_pulses", err_pulses, 260);
        check("sat_err_cnt",    o_err_cnt,  255);
        check("sat_locked",     o_locked,   0);

        // Clear coincident with a mismatch error: clear wins.
        run_periods(2, 3, 4);
        check("clr_locked_before", o_locked, 1);
        div_clk = 1'b0;
        repeat (3) tick();
        div_clk = 1'b1;
        tick();
        tick();
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        check("clr_err_pulse", o_err,     1);
        check("clr_err_cnt",   o_err_cnt, 0);
        check("clr_locked",    o_locked,  0);
        run_periods(2, 3, 4);
        run_periods(3, 3, 1);
        check("clr_then_count", o_err_cnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 Parameter WIDTH, default 8, sets the width of the period and high-time counters and of i_exp_period.
REQ-002 Parameter LOCK_COUNT, default 4, sets the number of consecutive matching periods required to assert lock.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 div_clk  input  1  divided clock under monitor (e.g. divide-by-7 output); sampled as data.
REQ-006 i_enable  input  1  monitor enable; low forces IDLE.
REQ-007 i_exp_period  input  WIDTH  expected div_clk period in clk cycles; must be 2 or more.
REQ-008 i_clr_err  input  1  synchronous clear of o_err_cnt.
REQ-009 o_rise  output  1  one-cycle pulse on each detected div_clk rising edge.
REQ-010 o_fall  output  1  one-cycle pulse on each detected div_clk falling edge.
REQ-011 o_period  output  WIDTH  last measured rise-to-rise period, in clk cycles.
REQ-012 o_high  output  WIDTH  last measured high time (rise to fall), in clk cycles.
REQ-013 o_locked  output  1  high while in LOCKED.
REQ-014 o_err  output  1  one-cycle pulse on a period mismatch in LOCKED, or on timeout.
REQ-015 o_err_cnt  output  8  saturating count of o_err pulses.

Function
REQ-016 div_clk passes through a 2-flop synchronizer (s1, s2) followed by a history flop s3.
- rise = s2 & ~s3
- fall = ~s2 & s3
REQ-017 o_rise and o_fall are registered; each appears 3 clk cycles after the corresponding div_clk transition is sampled.
REQ-018 The FSM has four states: IDLE, ACQ, MEAS, LOCKED.
REQ-019 FSM transitions are:
- any state -> IDLE when i_enable = 0
- IDLE -> ACQ when i_enable = 1
- ACQ -> MEAS on rise
REQ-020 Period counter cnt:
- held at 0 in IDLE and ACQ
- loaded to 1 on the rise that enters MEAS
- in MEAS and LOCKED, on each rise: o_period <= cnt, then cnt <= 1
- otherwise cnt <= cnt + 1
REQ-021 A period match is cnt == i_exp_period at a rise.
- match: good_cnt increments
- mismatch: good_cnt clears to 0
REQ-022 MEAS -> LOCKED when good_cnt reaches LOCK_COUNT; o_locked asserts in the cycle after that rise.
REQ-023 A mismatch in LOCKED causes all of the following:
- o_err pulse
- o_err_cnt increment
- good_cnt cleared
- transition to MEAS
REQ-024 A mismatch in MEAS clears good_cnt only; o_err does not pulse.
REQ-025 Timeout: in MEAS or LOCKED, when cnt reaches 2^WIDTH-1 with no rise, the block takes all of the following actions:
- o_err pulse
- o_err_cnt increment
- good_cnt cleared
- o_period <= 2^WIDTH-1
- transition to ACQ
REQ-026 High counter hcnt:
- loaded to 1 on rise
- increments while s2 = 1, saturating at 2^WIDTH-1
- on fall: o_high <= hcnt
REQ-027 o_err_cnt saturates at 255.
REQ-028 i_clr_err clears o_err_cnt; if i_clr_err and an error event occur in the same cycle, clear wins and the result is 0.
REQ-029 On entry to IDLE, cnt, hcnt and good_cnt clear; o_period, o_high and o_err_cnt hold.
REQ-030 rise and fall never occur in the same cycle; no special case is required.

Reset
REQ-031 While resetn = 0, all of the following are forced to 0:
- s1, s2, s3, cnt, hcnt, good_cnt
- o_rise, o_fall, o_period, o_high, o_locked, o_err, o_err_cnt
- FSM state = IDLE
REQ-032 Reset asserted mid-measurement discards the partial period; no o_err is generated.
REQ-033 After reset deassertion, the first rise acquires only; the first o_period update occurs on the second rise.

Verification
REQ-034 Lock: div_clk with period 7 cycles, i_exp_period = 7, i_enable = 1 -> o_period = 7 after the 2nd rise, o_locked = 1 after the 5th rise, o_err never pulses.
REQ-035 Mismatch: once locked, stretch one period to 8 -> o_period = 8, one o_err pulse, o_err_cnt = 1, o_locked = 0, relock after 4 good periods.
REQ-036 Timeout: once locked, hold div_clk at 0 -> o_err pulses when cnt = 255, state = ACQ, o_period = 255, o_err_cnt increments.
REQ-037 Duty: div_clk high 4 cycles, low 3 cycles -> o_high = 4, o_period = 7.
REQ-038 Error counter: force 260 error events -> o_err_cnt = 255; i_clr_err coincident with an error event -> o_err_cnt = 0.
REQ-039 Reset and enable: resetn pulsed low mid-period -> all outputs 0, no o_err pulse; i_enable dropped while locked -> o_locked = 0 next cycle, o_period held.
